// File: rtl/otter_rf_wb_arbiter.sv
// otter_rf_wb_arbiter: merges two register-file writeback streams into one registered write port.
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   A_VALID/A_READY/A_DEST/A_DATA  requester A (single-cycle ALU writeback)
//   B_VALID/B_READY/B_DEST/B_DATA  requester B (multi-cycle/load writeback)
//   FLUSH                      synchronous discard of all queued writes
//   WB_EN/WB_ADDR/WB_DATA      registered register-file write port
//   PENDING                    per-register "write in flight" mask (bit 0 never set)
//   IDLE                       both queues and output register empty
// Configuration: define OTTER_WB_ARB_RR_EN for round-robin arbitration; otherwise A has fixed priority.
`timescale 1ns/1ps
module otter_rf_wb_arbiter (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        A_VALID,
  output logic        A_READY,
  input  logic [4:0]  A_DEST,
  input  logic [31:0] A_DATA,
  input  logic        B_VALID,
  output logic        B_READY,
  input  logic [4:0]  B_DEST,
  input  logic [31:0] B_DATA,
  input  logic        FLUSH,
  output logic        WB_EN,
  output logic [4:0]  WB_ADDR,
  output logic [31:0] WB_DATA,
  output logic [31:0] PENDING,
  output logic        IDLE
);
  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;
  // Index 0 is requester A, index 1 is requester B; slot 0 of each FIFO is the head.
  ent_t       fifo_q [2][2];
  ent_t       fifo_d [2][2];
  ent_t       in_ent [2];
  logic [1:0] cnt_q  [2];
  logic [1:0] cnt_d  [2];
  logic [1:0] lvl    [2];
  logic [1:0] vld, ne, rdy, push, gnt;
  logic       gnt_a, gnt_b;
  ent_t       head;
  logic       wb_en_q, wb_en_d;
  logic [4:0] wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] pend;
`ifdef OTTER_WB_ARB_RR_EN
  logic       prio_b_q, prio_b_d;
`endif
  always_comb begin
    vld = {B_VALID, A_VALID};
    in_ent[0] = {A_DEST, A_DATA};
    in_ent[1] = {B_DEST, B_DATA};
    for (int r = 0; r < 2; r++) begin
      ne[r]   = cnt_q[r] != 2'd0;
      rdy[r]  = cnt_q[r] != 2'd2;
      push[r] = vld[r] & rdy[r] & ~FLUSH;
    end
  end
`ifdef OTTER_WB_ARB_RR_EN
  assign gnt_b = ~FLUSH & ne[1] & (~ne[0] | prio_b_q);
`else
  assign gnt_b = ~FLUSH & ne[1] & ~ne[0];
`endif
  assign gnt_a = ~FLUSH & ne[0] & ~gnt_b;
  assign gnt   = {gnt_b, gnt_a};
  always_comb begin
    head      = gnt_b ? fifo_q[1][0] : fifo_q[0][0];
    wb_en_d   = (gnt_a | gnt_b) & (head.dest != 5'd0);
    wb_addr_d = (gnt_a | gnt_b) ? head.dest : wb_addr_q;
    wb_data_d = (gnt_a | gnt_b) ? head.data : wb_data_q;
`ifdef OTTER_WB_ARB_RR_EN
    prio_b_d  = (gnt_a | gnt_b) ? gnt_a : prio_b_q;
`endif
    // Pop shifts the queue toward the head, then a push lands at the post-pop level.
    for (int r = 0; r < 2; r++) begin
      lvl[r]       = cnt_q[r] - {1'b0, gnt[r]};
      fifo_d[r][0] = gnt[r] ? fifo_q[r][1] : fifo_q[r][0];
      fifo_d[r][1] = fifo_q[r][1];
      if (push[r]) fifo_d[r][lvl[r][0]] = in_ent[r];
      cnt_d[r]     = FLUSH ? 2'd0 : lvl[r] + {1'b0, push[r]};
    end
  end
  always_comb begin
    pend = '0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 2; i++)
        if (cnt_q[r] > 2'(i)) pend[fifo_q[r][i].dest] = 1'b1;
    if (wb_en_q) pend[wb_addr_q] = 1'b1;
    pend[0] = 1'b0;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int r = 0; r < 2; r++) begin
        cnt_q[r]     <= 2'd0;
        fifo_q[r][0] <= '0;
        fifo_q[r][1] <= '0;
      end
      wb_en_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
`ifdef OTTER_WB_ARB_RR_EN
      prio_b_q  <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      fifo_q    <= fifo_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
`ifdef OTTER_WB_ARB_RR_EN
      prio_b_q  <= prio_b_d;
`endif
    end
  end
  assign A_READY = rdy[0];
  assign B_READY = rdy[1];
  assign WB_EN   = wb_en_q;
  assign WB_ADDR = wb_addr_q;
  assign WB_DATA = wb_data_q;
  assign PENDING = pend;
  assign IDLE    = ~ne[0] & ~ne[1] & ~wb_en_q;
endmodule
